// File: rtl/rej_eta_stream_pkg.sv
// Shared Dilithium constants and types used by the streaming secret-key sampler.
package rej_eta_stream_pkg;

  localparam int unsigned POLY_N        = 256;
  localparam int unsigned SHAKE256_RATE = 136;

  // Nibble rejection thresholds: accept iff t < threshold
  localparam int unsigned ETA2_REJ = 15;
  localparam int unsigned ETA4_REJ = 9;

  // t mod 5 == t - 5 * ((t * MOD5_MUL) >> MOD5_SHIFT), exact for 4-bit t
  localparam int unsigned MOD5_MUL   = 205;
  localparam int unsigned MOD5_SHIFT = 10;

  localparam int unsigned COEFF_BITS = 32;
  typedef logic signed [COEFF_BITS-1:0] coeff_t;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHi,
    StDone
  } state_e;

endpackage

// File: rtl/eta_nibble_map.sv
// Combinational map of one 4-bit nibble to an accept flag and a signed coefficient in [-ETA, ETA].
module eta_nibble_map
  import rej_eta_stream_pkg::*;
#(
  parameter int unsigned ETA     = 2,
  parameter int unsigned COEFF_W = 32
) (
  input  logic [3:0]                t,
  output logic                      accept,
  output logic signed [COEFF_W-1:0] coeff
);

  if (ETA == 2) begin : g_eta2
    logic [11:0] prod;
    logic [1:0]  quot;
    logic [3:0]  rem;

    always_comb begin
      prod   = 12'(t) * 12'(MOD5_MUL);
      quot   = 2'(prod >> MOD5_SHIFT);
      rem    = t - 4'(quot) * 4'd5;
      accept = t < 4'(ETA2_REJ);
      coeff  = COEFF_W'(5'sd2 - $signed({1'b0, rem}));
    end
  end else if (ETA == 4) begin : g_eta4
    always_comb begin
      accept = t < 4'(ETA4_REJ);
      coeff  = COEFF_W'(5'sd4 - $signed({1'b0, t}));
    end
  end else begin : g_bad_eta
    $error("eta_nibble_map: ETA must be 2 or 4");
  end

endmodule

// File: rtl/rej_eta_stream.sv
// Streaming rejection sampler: consumes squeezed bytes, writes accepted eta-bounded coefficients.
module rej_eta_stream
  import rej_eta_stream_pkg::*;
#(
  parameter int unsigned ETA     = 2,
  parameter int unsigned N       = POLY_N,
  parameter int unsigned COEFF_W = COEFF_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      coeff_we,
  output logic [7:0]                coeff_addr,
  output logic signed [COEFF_W-1:0] coeff_data,
  output logic [15:0]               bytes_used,
  output logic                      busy,
  output logic                      done
);

  localparam logic [8:0] CtrFull = 9'(N);

  state_e                     state_q, state_d;
  logic [8:0]                 ctr_q, ctr_d;
  logic [3:0]                 hi_q, hi_d;
  logic [15:0]                bytes_q, bytes_d;
  logic                       we_q, we_d;
  logic [7:0]                 addr_q, addr_d;
  logic signed [COEFF_W-1:0]  data_q, data_d;

  logic                       hs;
  logic                       eval_en;
  logic                       take;
  logic [3:0]                 nib;
  logic                       accept;
  logic signed [COEFF_W-1:0]  coeff;

  eta_nibble_map #(
    .ETA     (ETA),
    .COEFF_W (COEFF_W)
  ) u_map (
    .t      (nib),
    .accept (accept),
    .coeff  (coeff)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    hi_d    = hi_q;
    bytes_d = bytes_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    hs      = (state_q == StFetch) && in_valid;
    eval_en = hs || (state_q == StHi);
    nib     = (state_q == StHi) ? hi_q : in_data[3:0];
    take    = eval_en && accept;

    if (take) begin
      we_d   = 1'b1;
      addr_d = ctr_q[7:0];
      data_d = coeff;
      ctr_d  = ctr_q + 9'd1;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StFetch;
          ctr_d   = '0;
          bytes_d = '0;
        end
      end
      StFetch: begin
        if (hs) begin
          hi_d = in_data[7:4];
          if (bytes_q != 16'hFFFF) begin
            bytes_d = bytes_q + 16'd1;
          end
          // A final low-nibble accept drops the high nibble entirely
          state_d = (ctr_d == CtrFull) ? StDone : StHi;
        end
      end
      StHi: begin
        state_d = (ctr_d == CtrFull) ? StDone : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      hi_q    <= '0;
      bytes_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      hi_q    <= hi_d;
      bytes_q <= bytes_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign in_ready   = (state_q == StFetch);
  assign busy       = (state_q == StFetch) || (state_q == StHi);
  assign done       = (state_q == StDone);
  assign coeff_we   = we_q;
  assign coeff_addr = addr_q;
  assign coeff_data = data_q;
  assign bytes_used = bytes_q;

endmodule

// File: tb/tb_rej_eta_stream.sv
// Directed self-checking bench: an ETA=2 and an ETA=4 instance share the byte stream.
module tb_rej_eta_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;

  logic        ready_a, we_a, busy_a, done_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [15:0] bytes_a;

  logic        ready_b, we_b, busy_b, done_b;
  logic [7:0]  addr_b;
  logic [31:0] data_b;
  logic [15:0] bytes_b;

  int errors = 0;
  int checks = 0;

  logic [7:0]  wa_addr[$];
  logic [31:0] wa_data[$];
  logic        wa_done[$];
  logic [7:0]  wb_addr[$];
  logic [31:0] wb_data[$];

  always #5 clock = ~clock;

  rej_eta_stream #(.ETA(2), .N(256), .COEFF_W(32)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (ready_a),
    .coeff_we   (we_a),
    .coeff_addr (addr_a),
    .coeff_data (data_a),
    .bytes_used (bytes_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  rej_eta_stream #(.ETA(4), .N(256), .COEFF_W(32)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (ready_b),
    .coeff_we   (we_b),
    .coeff_addr (addr_b),
    .coeff_data (data_b),
    .bytes_used (bytes_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  always @(negedge clock) begin
    if (we_a) begin
      wa_addr.push_back(addr_a);
      wa_data.push_back(data_a);
      wa_done.push_back(done_a);
    end
    if (we_b) begin
      wb_addr.push_back(addr_b);
      wb_data.push_back(data_b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_addr.delete(); wa_data.delete(); wa_done.delete();
    wb_addr.delete(); wb_data.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge
  task automatic send(input logic [7:0] b, input int gap, input bit use_b);
    int n;
    for (int i = 0; i < gap; i++) @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!(use_b ? ready_b : ready_a) && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      chk("handshake_timeout", {63'd0, use_b ? ready_b : ready_a}, 64'd1);
    end else begin
      @(posedge clock);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
  endtask

  int exp_mix[13] = '{2, 2, -2, -2, 2, 0, 1, -1, -2, -2, 2, 2, -2};
  logic [7:0] mix_bytes[8] = '{8'h00, 8'hFF, 8'h9E, 8'h70, 8'h31, 8'hEE, 8'h5A, 8'hF4};

  initial begin
    int bad;
    int sz;

    // Reset state
    #2;
    chk("rst_we", {63'd0, we_a}, 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    chk("rst_ready", {63'd0, ready_a}, 64'd0);
    chk("rst_bytes", {48'd0, bytes_a}, 64'd0);
    @(negedge clock);
    do_reset();

    // ETA=2, byte 0x00 -> two writes of 2
    pulse_start();
    chk("t1_busy_after_start", {63'd0, busy_a}, 64'd1);
    send(8'h00, 0, 1'b0);
    settle();
    chk("t1_nwrites", 64'(wa_addr.size()), 64'd2);
    if (wa_addr.size() == 2) begin
      chk("t1_addr0", {56'd0, wa_addr[0]}, 64'd0);
      chk("t1_data0", {32'd0, wa_data[0]}, 64'd2);
      chk("t1_addr1", {56'd0, wa_addr[1]}, 64'd1);
      chk("t1_data1", {32'd0, wa_data[1]}, 64'd2);
    end
    chk("t1_bytes", {48'd0, bytes_a}, 64'd1);
    chk("t1_busy", {63'd0, busy_a}, 64'd1);
    chk("t1_done", {63'd0, done_a}, 64'd0);

    // ETA=2, 0xFF rejected entirely, then 0x9E -> -2, -2
    do_reset();
    pulse_start();
    send(8'hFF, 0, 1'b0);
    settle();
    chk("t2_ff_nwrites", 64'(wa_addr.size()), 64'd0);
    send(8'h9E, 0, 1'b0);
    settle();
    chk("t2_nwrites", 64'(wa_addr.size()), 64'd2);
    if (wa_addr.size() == 2) begin
      chk("t2_addr0", {56'd0, wa_addr[0]}, 64'd0);
      chk("t2_data0", {32'd0, wa_data[0]}, {32'd0, 32'hFFFF_FFFE});
      chk("t2_addr1", {56'd0, wa_addr[1]}, 64'd1);
      chk("t2_data1", {32'd0, wa_data[1]}, {32'd0, 32'hFFFF_FFFE});
    end
    chk("t2_bytes", {48'd0, bytes_a}, 64'd2);

    // ETA=4, 0x98 -> -4 (9 rejected), 0x10 -> 4, 3
    do_reset();
    pulse_start();
    send(8'h98, 0, 1'b1);
    send(8'h10, 0, 1'b1);
    settle();
    chk("t3_nwrites", 64'(wb_addr.size()), 64'd3);
    if (wb_addr.size() == 3) begin
      chk("t3_data0", {32'd0, wb_data[0]}, {32'd0, 32'hFFFF_FFFC});
      chk("t3_addr1", {56'd0, wb_addr[1]}, 64'd1);
      chk("t3_data1", {32'd0, wb_data[1]}, 64'd4);
      chk("t3_addr2", {56'd0, wb_addr[2]}, 64'd2);
      chk("t3_data2", {32'd0, wb_data[2]}, 64'd3);
    end
    chk("t3_bytes", {48'd0, bytes_b}, 64'd2);

    // ETA=2, full polynomial from 128 zero bytes
    do_reset();
    pulse_start();
    for (int i = 0; i < 128; i++) send(8'h00, 0, 1'b0);
    settle();
    chk("t4_nwrites", 64'(wa_addr.size()), 64'd256);
    if (wa_addr.size() == 256) begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (wa_addr[i] !== 8'(i) || wa_data[i] !== 32'd2) bad++;
      end
      chk("t4_order_bad", 64'(bad), 64'd0);
      chk("t4_done_at_254", {63'd0, wa_done[254]}, 64'd0);
      chk("t4_done_at_255", {63'd0, wa_done[255]}, 64'd1);
    end
    chk("t4_bytes", {48'd0, bytes_a}, 64'd128);
    chk("t4_done", {63'd0, done_a}, 64'd1);
    chk("t4_busy", {63'd0, busy_a}, 64'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (ready_a !== 1'b0) bad++;
    end
    chk("t4_ready_after_done", 64'(bad), 64'd0);

    // ETA=2, 255 filled then 0x70 -> single final write, high nibble dropped
    do_reset();
    pulse_start();
    for (int i = 0; i < 127; i++) send(8'h00, 0, 1'b0);
    send(8'hF0, 0, 1'b0);
    settle();
    sz = wa_addr.size();
    chk("t5_prefill", 64'(sz), 64'd255);
    chk("t5_bytes_pre", {48'd0, bytes_a}, 64'd128);
    send(8'h70, 0, 1'b0);
    settle();
    chk("t5_nwrites", 64'(wa_addr.size()), 64'd256);
    if (wa_addr.size() == 256) begin
      chk("t5_last_addr", {56'd0, wa_addr[255]}, 64'd255);
      chk("t5_last_data", {32'd0, wa_data[255]}, 64'd2);
      chk("t5_last_done", {63'd0, wa_done[255]}, 64'd1);
    end
    chk("t5_bytes", {48'd0, bytes_a}, 64'd129);
    chk("t5_done", {63'd0, done_a}, 64'd1);

    // Mid-polynomial asynchronous reset at ctr=100
    do_reset();
    pulse_start();
    for (int i = 0; i < 50; i++) send(8'h00, 0, 1'b0);
    settle();
    chk("t6_ctr100", 64'(wa_addr.size()), 64'd100);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_busy", {63'd0, busy_a}, 64'd0);
    chk("t6_rst_bytes", {48'd0, bytes_a}, 64'd0);
    chk("t6_rst_addr", {56'd0, addr_a}, 64'd0);
    chk("t6_rst_data", {32'd0, data_a}, 64'd0);
    chk("t6_rst_ready", {63'd0, ready_a}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    clear_log();
    @(negedge clock);
    pulse_start();
    chk("t6_fresh_bytes", {48'd0, bytes_a}, 64'd0);
    for (int i = 0; i < 8; i++) send(mix_bytes[i], $urandom_range(0, 3), 1'b0);
    settle();
    chk("t6_nwrites", 64'(wa_addr.size()), 64'd13);
    if (wa_addr.size() == 13) begin
      bad = 0;
      for (int i = 0; i < 13; i++) begin
        if (wa_addr[i] !== 8'(i) || wa_data[i] !== 32'(exp_mix[i])) bad++;
      end
      chk("t6_seq_bad", 64'(bad), 64'd0);
    end
    chk("t6_bytes", {48'd0, bytes_a}, 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
